tdm_demux_14: RTL and testbench

TDM_DEMUX_14 -- requirements
Module: tdm_demux_14

---
 rtl/tdm_demux_14.sv | 181 ++++++++++++++++++
 tb/tb_tdm_demux_14.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_14.sv
// tdm_demux_14 -- four-lane time-division demultiplexer.
// A serial stream carries one lane sample per enabled cycle, in slot order
// a, b, c, d. A frame starts with sync high on the slot-0 sample. Samples
// are collected in shadow registers, and all four lanes are published on
// the same edge once a full frame has arrived.
// Optional feature macro: TDM_DEMUX_PARITY_EN adds a fifth slot carrying
// even parity over all bits of samples 0 to 3. Only din[0] of the parity
// sample is compared. The lanes update only when parity matches.
module tdm_demux_14 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [2:0]       slot,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             par_err
);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic [WIDTH-1:0] sh3_q, sh3_d;
  logic             par_err_q, par_err_d;
  logic             par_calc;
`endif

  // Next-state logic: slot sequencing, shadow capture, frame publish and error pulses.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch;
    // combinational logic uses blocking assignments.
    state_d       = state_q;
    slot_d        = slot_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    sh3_d         = sh3_q;
    par_err_d     = 1'b0;
    par_calc      = ^{sh0_q, sh1_q, sh2_q, sh3_q};
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            sh0_d   = din;
            slot_d  = 3'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync anywhere but slot 0 aborts the partial frame; din still opens a new one.
            sync_err_d = (slot_q != 3'd0);
            sh0_d      = din;
            slot_d     = 3'd1;
          end else if (slot_q == 3'd0) begin
            // The frame boundary was expected but sync is missing: lose lock.
            sync_err_d = 1'b1;
            state_d    = IDLE;
          end else if (slot_q == LAST_SLOT) begin
            slot_d = 3'd0;
`ifdef TDM_DEMUX_PARITY_EN
            if (din[0] == par_calc) begin
              a_d           = sh0_q;
              b_d           = sh1_q;
              c_d           = sh2_q;
              d_d           = sh3_q;
              frame_valid_d = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
`else
            a_d           = sh0_q;
            b_d           = sh1_q;
            c_d           = sh2_q;
            d_d           = din;
            frame_valid_d = 1'b1;
`endif
          end else begin
            case (slot_q)
              3'd1:    sh1_d = din;
              3'd2:    sh2_d = din;
`ifdef TDM_DEMUX_PARITY_EN
              3'd3:    sh3_d = din;
`endif
              default: ;
            endcase
            slot_d = slot_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register. Reset clears the FSM, the slot counter, the shadows, the lanes and the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow registers are reset too. A partial frame must never
      // leak into the lanes after reset.
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      sh3_q         <= '0;
      par_err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples pre-edge values.
      state_q       <= state_d;
      slot_q        <= slot_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      sh3_q         <= sh3_d;
      par_err_q     <= par_err_d;
`endif
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign slot        = slot_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = par_err_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_14.sv
// tb_tdm_demux_14 -- directed scenarios followed by random traffic for
// tdm_demux_14. Each DUT output is compared against a frame-level model
// that keeps the samples of the current frame in a queue.
module tb_tdm_demux_14;

  localparam int W = 1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] a, b, c, d;
  logic [2:0]   slot;
  logic         frame_valid, sync_err, par_err;

  int errors = 0;
  int checks = 0;

  // Model state: the lock flag, the samples gathered so far, the lanes and the pulses.
  bit           m_run;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_a, m_b, m_c, m_d;
  logic         m_fv, m_se, m_pe;

  tdm_demux_14 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .a(a), .b(b), .c(c), .d(d), .slot(slot),
    .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_frame.delete();
    m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
  endtask

  // Advance the model by one clock edge, working at the level of whole frames.
  task automatic model_step(input bit e, input bit s, input logic [W-1:0] x);
    bit p;
    m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
    if (e) begin
      if (s) begin
        if (m_run && m_frame.size() != 0) m_se = 1'b1;
        m_frame.delete();
        m_frame.push_back(x);
        m_run = 1'b1;
      end else if (m_run) begin
        if (m_frame.size() == 0) begin
          m_se  = 1'b1;
          m_run = 1'b0;
        end else begin
          m_frame.push_back(x);
          if (m_frame.size() == FLEN) begin
            p = 1'b0;
            for (int i = 0; i < 4; i++) p = p ^ (^m_frame[i]);
            if (FLEN == 4 || m_frame[FLEN-1][0] == p) begin
              m_a = m_frame[0]; m_b = m_frame[1]; m_c = m_frame[2]; m_d = m_frame[3];
              m_fv = 1'b1;
            end else begin
              m_pe = 1'b1;
            end
            m_frame.delete();
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] exp_slot;
    exp_slot = m_run ? 3'(m_frame.size()) : 3'd0;
    check({tag, ".a"}, 32'(a), 32'(m_a));
    check({tag, ".b"}, 32'(b), 32'(m_b));
    check({tag, ".c"}, 32'(c), 32'(m_c));
    check({tag, ".d"}, 32'(d), 32'(m_d));
    check({tag, ".slot"}, 32'(slot), 32'(exp_slot));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(m_se));
    check({tag, ".par_err"}, 32'(par_err), 32'(m_pe));
  endtask

  // Drive one cycle of inputs, then compare the outputs 1 ns after the edge.
  task automatic step(input string tag, input bit e, input bit s, input logic [W-1:0] x);
    en = e; sync = s; din = x;
    @(posedge clk);
    model_step(e, s, x);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges; the outputs must clear before any clock edge.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one full frame; in a parity build a correct parity sample is appended.
  task automatic send_frame(input string tag, input logic [W-1:0] s0, input logic [W-1:0] s1,
                            input logic [W-1:0] s2, input logic [W-1:0] s3);
    step(tag, 1'b1, 1'b1, s0);
    step(tag, 1'b1, 1'b0, s1);
    step(tag, 1'b1, 1'b0, s2);
    step(tag, 1'b1, 1'b0, s3);
`ifdef TDM_DEMUX_PARITY_EN
    step(tag, 1'b1, 1'b0, W'(^{s0, s1, s2, s3}));
`endif
  endtask

  initial begin
    bit e, s;
    logic [W-1:0] x;
    en = 1'b0; sync = 1'b0; din = '0; rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame.
    send_frame("nominal", 1, 0, 1, 1);
    check("nominal_a", 32'(a), 32'd1);
    check("nominal_b", 32'(b), 32'd0);
    check("nominal_c", 32'(c), 32'd1);
    check("nominal_d", 32'(d), 32'd1);
    check("nominal_fv", 32'(frame_valid), 32'd1);

    // Back-to-back frames.
    send_frame("b2b", 1, 0, 1, 1);
    check("b2b_fv1", 32'(frame_valid), 32'd1);
    send_frame("b2b", 0, 1, 0, 0);
    check("b2b_fv2", 32'(frame_valid), 32'd1);
    check("b2b_lanes", 32'({a, b, c, d}), 32'b0100);

    // Enable gaps between samples 2 and 3.
    step("gap", 1, 1, 1);
    step("gap", 1, 0, 0);
    for (int i = 0; i < 3; i++) step("gap_idle", 0, 0, 0);
    step("gap", 1, 0, 1);
    step("gap", 1, 0, 1);
`ifdef TDM_DEMUX_PARITY_EN
    step("gap", 1, 0, 1);
`endif
    check("gap_lanes", 32'({a, b, c, d}), 32'b1011);
    check("gap_fv", 32'(frame_valid), 32'd1);

    // Early sync at slot 2.
    step("early", 1, 1, 0);
    step("early", 1, 0, 0);
    step("early", 1, 1, 0);
    check("early_err", 32'(sync_err), 32'd1);
    check("early_lanes_held", 32'({a, b, c, d}), 32'b1011);
    step("early", 1, 0, 1);
    step("early", 1, 0, 1);
    step("early", 1, 0, 0);
`ifdef TDM_DEMUX_PARITY_EN
    step("early", 1, 0, 0);
`endif
    check("early_new_frame", 32'({a, b, c, d}), 32'b0110);

    // Missing sync at slot 0 drops to IDLE; later samples without sync are ignored.
    step("nosync", 1, 0, 1);
    check("nosync_err", 32'(sync_err), 32'd1);
    step("nosync", 1, 0, 1);
    step("nosync", 1, 0, 0);

    // Reset in the middle of a frame.
    step("midrst", 1, 1, 1);
    step("midrst", 1, 0, 1);
    apply_reset("midrst_reset");
    check("midrst_lanes", 32'({a, b, c, d}), 32'd0);
    for (int i = 0; i < FLEN; i++) step("midrst_wait", 1, 0, 1);
    send_frame("midrst_resync", 1, 1, 0, 1);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity sample, correct and then wrong.
    send_frame("par_ok", 0, 0, 0, 0);
    step("par_ok", 1, 1, 1); step("par_ok", 1, 0, 0); step("par_ok", 1, 0, 1);
    step("par_ok", 1, 0, 1); step("par_ok", 1, 0, 1);
    check("par_ok_fv", 32'(frame_valid), 32'd1);
    send_frame("par_bad", 0, 0, 0, 0);
    step("par_bad", 1, 1, 1); step("par_bad", 1, 0, 0); step("par_bad", 1, 0, 1);
    step("par_bad", 1, 0, 1); step("par_bad", 1, 0, 0);
    check("par_bad_pe", 32'(par_err), 32'd1);
    check("par_bad_lanes_held", 32'({a, b, c, d}), 32'd0);
`endif

    // Random traffic, biased toward well-formed frames.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) apply_reset("rand_reset");
      e = ($urandom_range(0, 9) != 0);
      if (!m_run || m_frame.size() == 0) s = ($urandom_range(0, 9) != 0);
      else s = ($urandom_range(0, 24) == 0);
      x = W'($urandom);
      step("rand", e, s, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
